mips_avalon_multiport_bridge: RTL and testbench

//   Parametrised bridge from N_PORTS independent CPU memory ports (instr, data, debug...) to one Avalon-MM master.

---
 rtl/mips_bus_pkg.sv | 26 ++
 rtl/mips_bus_arbiter.sv | 59 +++++
 rtl/mips_avalon_multiport_bridge.sv | 137 +++++++++++++
 tb/tb_mips_avalon_multiport_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS multi-port Avalon bridge: FSM states, port index width, bus command.
// Command fields are sized for the default bus; the bridge casts to its own parameter widths.
package mips_bus_pkg;

  localparam int BUS_ADDR_W  = 32;
  localparam int BUS_DATA_W  = 32;
  localparam int BUS_BE_W    = BUS_DATA_W / 8;
  localparam int DEF_N_PORTS = 2;

  typedef enum logic {IDLE, BUS} bridge_state_t;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [port_idx_w(DEF_N_PORTS)-1:0] port_idx_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_DATA_W-1:0] wdata;
  } avl_cmd_t;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Combinational grant over pending ports. MIPS_BUS_RR_ARB_EN selects round-robin with a
// start pointer register; otherwise fixed priority, lowest index first.
module mips_bus_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
`ifdef MIPS_BUS_RR_ARB_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
`endif
  input  logic [N_PORTS-1:0] req,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

`ifdef MIPS_BUS_RR_ARB_EN
  // ptr_q is where the next search starts: one past the last completed port.
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (upd) begin
      ptr_q <= (upd_idx == IDX_W'(N_PORTS - 1)) ? '0 : upd_idx + 1'b1;
    end
  end

  // First loop is the wrap-around fallback; second overrides with the lowest port at or after ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) >= ptr_q)) begin
        gnt_idx = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mips_avalon_multiport_bridge.sv
// Serialises N_PORTS stallable MIPS memory ports onto one Avalon-MM master; advance stalls the core.
// Arbitration is round-robin when MIPS_BUS_RR_ARB_EN is defined, fixed lowest-index priority otherwise.
module mips_avalon_multiport_bridge
  import mips_bus_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PORTS-1:0]            req_valid,
  input  logic [N_PORTS-1:0]            req_write,
  input  logic [N_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [N_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0] req_be,
  output logic [N_PORTS*DATA_W-1:0]     rsp_rdata,
  output logic [N_PORTS-1:0]            rsp_done,
  output logic                          advance,
  output logic [ADDR_W-1:0]             address,
  output logic                          read,
  output logic                          write,
  output logic [DATA_W/8-1:0]           byteenable,
  output logic [DATA_W-1:0]             writedata,
  input  logic                          waitrequest,
  input  logic [DATA_W-1:0]             readdata
);

  localparam int                BE_W       = DATA_W / 8;
  localparam int                IDX_W      = port_idx_w(N_PORTS);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);

  logic [ADDR_W-1:0] p_addr  [N_PORTS];
  logic [DATA_W-1:0] p_wdata [N_PORTS];
  logic [BE_W-1:0]   p_be    [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign p_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign p_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
    assign p_be[i]    = req_be[i*BE_W +: BE_W];
  end

  bridge_state_t                    state_q, state_d;
  avl_cmd_t                         cmd_q, cmd_d;
  logic [IDX_W-1:0]                 g_q, g_d;
  logic [N_PORTS-1:0]               done_q, done_set;
  logic [N_PORTS-1:0][DATA_W-1:0]   hold_q;
  logic [N_PORTS-1:0]               served;
  logic                             completing;
  logic                             gnt_vld;
  logic [IDX_W-1:0]                 gnt_idx;

  mips_bus_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
`ifdef MIPS_BUS_RR_ARB_EN
    .clk     (clk),
    .reset   (reset),
    .upd     (|done_set),
    .upd_idx (g_d),
`endif
    .req     (req_valid & ~done_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign completing = (state_q == BUS) && !waitrequest;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    g_d      = g_q;
    done_set = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          g_d = gnt_idx;
          // A write with no enabled bytes has nothing to put on the bus.
          if (req_write[gnt_idx] && (p_be[gnt_idx] == '0)) begin
            done_set[gnt_idx] = 1'b1;
          end else begin
            cmd_d.addr  = BUS_ADDR_W'(p_addr[gnt_idx] & ~ALIGN_MASK);
            cmd_d.rd    = !req_write[gnt_idx];
            cmd_d.wr    = req_write[gnt_idx];
            cmd_d.be    = req_write[gnt_idx] ? BUS_BE_W'(p_be[gnt_idx]) : '1;
            cmd_d.wdata = req_write[gnt_idx] ? BUS_DATA_W'(p_wdata[gnt_idx]) : '0;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest) begin
          done_set[g_q] = 1'b1;
          cmd_d.rd      = 1'b0;
          cmd_d.wr      = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      g_q     <= '0;
      done_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      g_q     <= g_d;
      done_q  <= advance ? '0 : (done_q | done_set);
      if (completing && cmd_q.rd) begin
        hold_q[g_q] <= readdata;
      end
    end
  end

  // The completing read bypasses the hold register so the core sees data in the same step.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign served[i] = !req_valid[i] || done_q[i] || (completing && (g_q == IDX_W'(i)));
    assign rsp_rdata[i*DATA_W +: DATA_W] =
      (completing && cmd_q.rd && (g_q == IDX_W'(i))) ? readdata : hold_q[i];
  end

  assign advance    = &served;
  assign rsp_done   = req_valid & served;
  assign address    = ADDR_W'(cmd_q.addr);
  assign read       = cmd_q.rd;
  assign write      = cmd_q.wr;
  assign byteenable = BE_W'(cmd_q.be);
  assign writedata  = DATA_W'(cmd_q.wdata);

endmodule

// File: tb/tb_mips_avalon_multiport_bridge.sv
// Scoreboard bench for the two-port bridge: expected bus accesses are queued at drive time
// and popped as the bench-side Avalon slave sees each command complete.
module tb_mips_avalon_multiport_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_done;
  logic        advance;
  logic [31:0] address;
  logic        read, write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  mips_avalon_multiport_bridge #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_rdata(rsp_rdata), .rsp_done(rsp_done), .advance(advance),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hold_m [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic drive(input int p, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    req_valid[p]          = 1'b1;
    req_write[p]          = wr;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = wd;
    req_be[p*4 +: 4]      = be;
  endtask

  // Queue the access the bus should see; a is the word-aligned address expected on the bus.
  task automatic expect_acc(input int p, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.port = p;
    e.wr   = wr;
    e.addr = a;
    e.dat  = wr ? wd : mem_val(a);
    e.be   = wr ? be : 4'hF;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle;
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  // Acts as the Avalon slave with `waits` stall cycles per command until advance.
  task automatic run_step(input int waits, input int exp_cyc, input string name, output bit pulse);
    int          cyc      = 0;
    int          wcnt     = 0;
    int          p;
    logic [1:0]  seen     = '0;
    logic [1:0]  newly;
    bit          unstable = 1'b0;
    bit          hold_bad = 1'b0;
    bit          fin      = 1'b0;
    bit          cmp;
    logic [69:0] cmd0     = '0;
    logic [71:0] obs, expv;
    exp_t        e;
    pulse = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      if (read || write) begin
        pulse = 1'b1;
        if (wcnt == 0) cmd0 = {read, write, address, byteenable, writedata};
        else if ({read, write, address, byteenable, writedata} !== cmd0) unstable = 1'b1;
        if (wcnt < waits) begin
          waitrequest = 1'b1;
          readdata    = 32'hBAADF00D;
          wcnt++;
        end else begin
          waitrequest = 1'b0;
          readdata    = mem_val(address);
          wcnt        = 0;
        end
      end else begin
        waitrequest = 1'b0;
        readdata    = 32'hBAADF00D;
      end
      #1;
      newly = rsp_done & ~seen;
      cmp   = (read || write) && !waitrequest;
      for (int i = 0; i < 2; i++) begin
        if (!(cmp && read && newly[i]) && (rsp_rdata[i*32 +: 32] !== hold_m[i])) hold_bad = 1'b1;
      end
      if (cmp) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_access: got unexpected access at %h, required none", name, address);
        end else begin
          e     = exp_q.pop_front();
          p     = newly[1] ? 1 : 0;
          obs   = {newly, read, write, address, byteenable,
                   write ? writedata : rsp_rdata[p*32 +: 32]};
          expv  = {2'b01 << e.port, !e.wr, e.wr, e.addr, e.be, e.dat};
          if (obs !== expv) $display("FAIL %s_access: got %h required %h", name, obs, expv);
          else n_pass++;
          if (!e.wr) hold_m[e.port] = e.dat;
        end
      end
      seen |= rsp_done;
      if (advance) begin
        fin = 1'b1;
      end else if (cyc >= 300) begin
        n_checks++;
        $display("FAIL %s_timeout: got no advance after %0d cycles, required advance", name, cyc);
        fin = 1'b1;
      end
    end
    waitrequest = 1'b0;
    n_checks++;
    if (cyc !== exp_cyc) $display("FAIL %s_adv_cycle: got %0d required %0d", name, cyc, exp_cyc);
    else n_pass++;
    n_checks++;
    if (rsp_done !== req_valid) $display("FAIL %s_rsp_done: got %b required %b", name, rsp_done, req_valid);
    else n_pass++;
    n_checks++;
    if (unstable) $display("FAIL %s_stable: got command change during waitrequest, required stable", name);
    else n_pass++;
    n_checks++;
    if (hold_bad) $display("FAIL %s_hold: got rsp_rdata differing from held data, required held data", name);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_missing: got %0d accesses outstanding, required 0", name, exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    waitrequest = 1'b0; readdata = '0;
    hold_m[0] = '0; hold_m[1] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({read, write, address, byteenable, writedata} !== 70'h0)
      $display("FAIL reset_cmd: got %h required 0", {read, write, address, byteenable, writedata});
    else n_pass++;
    n_checks++;
    if (advance !== 1'b1) $display("FAIL reset_advance: got %b required 1", advance);
    else n_pass++;
    n_checks++;
    if ({rsp_done, rsp_rdata} !== 66'h0) $display("FAIL reset_rsp: got %h required 0", {rsp_done, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_single_read;
    bit pulse;
    drive(1, 1'b0, 32'h100, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_step(0, 1, "single_read", pulse);
    idle_cycle();
  endtask

  task automatic test_two_port_waits;
    bit pulse;
    drive(0, 1'b0, 32'h040, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h080, 32'h0, 4'h0);
    expect_acc(0, 1'b0, 32'h040, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h080, 32'h0, 4'h0);
    run_step(3, 9, "two_port_waits", pulse);
    idle_cycle();
  endtask

  task automatic test_write;
    bit pulse;
    drive(0, 1'b1, 32'h204, 32'hCAFEF00D, 4'b0011);
    expect_acc(0, 1'b1, 32'h204, 32'hCAFEF00D, 4'b0011);
    run_step(2, 3, "write", pulse);
    idle_cycle();
  endtask

  task automatic test_write_be0;
    bit pulse;
    drive(0, 1'b1, 32'h208, 32'h11111111, 4'b0000);
    run_step(0, 1, "write_be0", pulse);
    n_checks++;
    if (pulse) $display("FAIL write_be0_pulse: got bus command, required none");
    else n_pass++;
    idle_cycle();
  endtask

  task automatic test_arbitration;
    bit pulse;
    drive(1, 1'b0, 32'h0C0, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h0C0, 32'h0, 4'h0);
    run_step(0, 1, "arb_p1_only", pulse);
    idle_cycle();
    drive(0, 1'b0, 32'h010, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h020, 32'h0, 4'h0);
    expect_acc(0, 1'b0, 32'h010, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h020, 32'h0, 4'h0);
    run_step(0, 3, "arb_both_a", pulse);
    idle_cycle();
    // Unaligned byte address must appear word aligned on the bus.
    drive(0, 1'b0, 32'h0C3, 32'h0, 4'h0);
    expect_acc(0, 1'b0, 32'h0C0, 32'h0, 4'h0);
    run_step(0, 1, "arb_p0_unaligned", pulse);
    idle_cycle();
    drive(0, 1'b0, 32'h030, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h034, 32'h0, 4'h0);
`ifdef MIPS_BUS_RR_ARB_EN
    expect_acc(1, 1'b0, 32'h034, 32'h0, 4'h0);
    expect_acc(0, 1'b0, 32'h030, 32'h0, 4'h0);
`else
    expect_acc(0, 1'b0, 32'h030, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h034, 32'h0, 4'h0);
`endif
    run_step(0, 3, "arb_both_b", pulse);
    idle_cycle();
  endtask

  task automatic test_reset_mid_access;
    bit pulse;
    waitrequest = 1'b1;
    drive(0, 1'b0, 32'h300, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    n_checks++;
    if (read !== 1'b1) $display("FAIL midreset_pre: got read=%b required 1", read);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({read, write} !== 2'b00) $display("FAIL midreset_cmd: got %b required 00", {read, write});
    else n_pass++;
    n_checks++;
    if ({rsp_done, rsp_rdata} !== 66'h0) $display("FAIL midreset_clear: got %h required 0", {rsp_done, rsp_rdata});
    else n_pass++;
    reset = 1'b0; req_valid = '0; waitrequest = 1'b0;
    hold_m[0] = '0; hold_m[1] = '0;
    @(posedge clk);
    #1;
    drive(1, 1'b0, 32'h100, 32'h0, 4'h0);
    expect_acc(1, 1'b0, 32'h100, 32'h0, 4'h0);
    run_step(1, 2, "post_reset", pulse);
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_two_port_waits();
    test_write();
    test_write_be0();
    test_arbitration();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
